result_capture: RTL

Synthesizable successor to the simulation-only result dump: captures the filter's output pixel stream (`mem_write_en` / `bus_out` beats) into an on-chip frame buffer and exposes a read-back port for UART or VGA readout. Supported features:
- Parametrised pixel width, buffer depth and frame length.
- Leading beats to discard (pipeline warm-up).
- Single-shot or continuous frame mode.
- Sticky overflow reporting.

---
 rtl/img_pkg.sv | 17 +
 rtl/capture_ram.sv | 24 ++
 rtl/result_capture.sv | 129 ++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image-pipeline types and default geometry
package img_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_SKIP    = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_DONE    = 2'd3
  } cap_state_e;

  // 98x98 output of the filter core, stored in a 10000-entry buffer
  localparam int IMG_WIDTH     = 8;
  localparam int IMG_DEPTH     = 10000;
  localparam int IMG_ADDR_W    = 14;
  localparam int IMG_FRAME_LEN = 9604;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port frame buffer, registered read-first port
module capture_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on storage or read register so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/result_capture.sv
// rtl/result_capture.sv - captures the filter output stream into a readable frame buffer
module result_capture
  import img_pkg::*;
#(
  parameter int WIDTH     = IMG_WIDTH,
  parameter int DEPTH     = IMG_DEPTH,
  parameter int ADDR_W    = IMG_ADDR_W,
  parameter int FRAME_LEN = IMG_FRAME_LEN,
  parameter int SKIP      = 1,
  parameter int CONT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              mem_write_en,
  input  logic [WIDTH-1:0]  bus_out,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] pix_cnt,
  output logic [7:0]        frame_cnt
);

  localparam cap_state_e START_STATE = (SKIP > 0) ? CAP_SKIP : CAP_CAPTURE;

  cap_state_e       state;
  cap_state_e       state_nxt;
  logic [15:0]      skip_cnt;
  logic             last_skip;
  logic             last_pix;
  logic             cap_we;
  logic             rd_hit;
  logic             rd_hit_q;
  logic [WIDTH-1:0] ram_q;

  assign last_skip = (skip_cnt == 16'(SKIP - 1));
  assign last_pix  = (pix_cnt == ADDR_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CAP_IDLE;
    else      state <= state_nxt;
  end

  // arm has priority over everything, including a beat in the same cycle
  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = START_STATE;
    end else begin
      case (state)
        CAP_SKIP:    if (mem_write_en && last_skip) state_nxt = CAP_CAPTURE;
        CAP_CAPTURE: if (mem_write_en && last_pix)  state_nxt = CAP_DONE;
        CAP_DONE:    if (CONT != 0)                 state_nxt = START_STATE;
        default:     ;
      endcase
    end
  end

  always_comb begin
    busy   = (state == CAP_SKIP) || (state == CAP_CAPTURE);
    done   = (state == CAP_DONE);
    cap_we = (state == CAP_CAPTURE) && mem_write_en && !arm;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt   <= '0;
      skip_cnt  <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else if (arm) begin
      pix_cnt  <= '0;
      skip_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        CAP_SKIP: if (mem_write_en) skip_cnt <= skip_cnt + 16'd1;
        CAP_CAPTURE: begin
          if (mem_write_en) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (last_pix) frame_cnt <= frame_cnt + 8'd1;
          end
        end
        CAP_DONE: begin
          if (mem_write_en) overflow <= 1'b1;
          if (CONT != 0) begin
            pix_cnt  <= '0;
            skip_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Out-of-frame addresses never touch the RAM and read back as zero
  assign rd_hit = rd_en && (32'(rd_addr) < FRAME_LEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_hit_q <= rd_hit;
    end
  end

  assign rd_data = rd_hit_q ? ram_q : '0;

  capture_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (cap_we),
    .wr_addr (pix_cnt),
    .wr_data (bus_out),
    .rd_en   (rd_hit),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule
